stage_sequencer: RTL and testbench
==================================

// Module: stage_sequencer
// PURPOSE
//  Multi-cycle control FSM for TinyCPU. Generates the `STAGE_WIDTH stage code that
//  gates pc_control (pc_en = stage==`STAGE_FETCH), register write-back and memory
//  requests. Handles instruction/data memory ready handshakes, halt and a memory
//  timeout. Sits beside pc_control; one instance per core.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles waiting on any *_mem_ready before timeout_err (>=2)
//  CNT_WIDTH    32  width of instr_count / cycle_count
// PORTS
//  clk                       in   1            core clock, all state on posedge
//  rst                       in   1            synchronous, active-high reset
//  start                     in   1            leave IDLE and begin fetching
//  current_instruction_type  in   5            decoded type (`INSTR_* codes)
//  instr_mem_ready           in   1            instruction word valid this cycle
//  data_mem_ready            in   1            load data valid / store accepted
//  stage                     out  STAGE_WIDTH  current stage code (`STAGE_*)
//  instr_mem_req             out  1            instruction read request
//  data_mem_req              out  1            data access request
//  data_mem_we               out  1            1 = store, 0 = load (valid with req)
//  reg_write_en              out  1            register file write strobe
//  halted                    out  1            core stopped (halt or timeout)
//  timeout_err               out  1            sticky: memory wait exceeded limit
//  instr_count               out  CNT_WIDTH    retired instructions
//  cycle_count               out  CNT_WIDTH    cycles since start, frozen when halted
// BEHAVIOUR
//  Reset: state=IDLE; stage=`STAGE_IDLE; all strobes 0; halted=0; timeout_err=0;
//   counters 0. Reset wins over every other input in the same cycle, incl. mid-wait.
//  States / stage codes (one code per state): IDLE, IWAIT, FETCH, DECODE, EXECUTE,
//   MWAIT, WRITEBACK, HALT.
//  IDLE: start=1 -> IWAIT next cycle. Otherwise hold.
//  IWAIT: instr_mem_req=1. ready=1 -> FETCH. Wait counter reaching MEM_TIMEOUT
//   with ready still 0 -> HALT, timeout_err=1.
//  FETCH: exactly one cycle per instruction (so PC advances once) -> DECODE.
//  DECODE: one cycle -> EXECUTE.
//  EXECUTE: one cycle. `INSTR_HALT -> HALT; `INSTR_LOAD/`INSTR_STORE -> MWAIT;
//   all others (incl. `INSTR_JUMP) -> WRITEBACK.
//  MWAIT: data_mem_req=1, data_mem_we=1 for store. ready=1 -> WRITEBACK;
//   timeout identical to IWAIT. current_instruction_type is latched on EXECUTE
//   exit; input changes during MWAIT/WRITEBACK are ignored.
//  WRITEBACK: one cycle; reg_write_en=1 unless latched type is STORE or JUMP;
//   instr_count++; -> IWAIT.
//  HALT: halted=1, all strobes 0, absorbing until rst. start ignored.
//  Request outputs are Moore (from state only); ready may be high on the first
//   wait cycle, giving min instruction latency 5 cycles (IWAIT,F,D,E,WB), 6 with MWAIT.
//  Wait counter clears on entry to IWAIT/MWAIT; counts cycles with ready=0; timeout
//   fires when count == MEM_TIMEOUT-1 and ready=0 (MEM_TIMEOUT wait cycles total).
//   ready=1 on that same cycle takes priority: normal progress, no error.
//  cycle_count increments every cycle outside IDLE/HALT; both counters wrap
//   modulo 2^CNT_WIDTH silently.
// STRUCTURE
//  arch_defines.v: add `STAGE_IDLE, `STAGE_IWAIT, `STAGE_DECODE, `STAGE_EXECUTE,
//   `STAGE_MWAIT, `STAGE_WRITEBACK, `STAGE_HALT and `INSTR_LOAD/STORE/HALT beside
//   existing `STAGE_FETCH / `INSTR_JUMP; widen `STAGE_WIDTH if needed (>=3 bits).
//  One sub-module: mem_wait_timer (clear, ready, MEM_TIMEOUT -> expired).
//  FSM register + next-state block + Moore output decode in this module.
// TESTING
//  1 rst, start=1, instr ready=1 at once, type=ADD -> stages IWAIT,F,D,E,WB;
//    reg_write_en one cycle; instr_count=1 after cycle 5; pc_en 1 cycle only.
//  2 LOAD, data ready after 3 MWAIT cycles -> 8 cycles total, data_mem_we=0,
//    reg_write_en=1; STORE same -> data_mem_we=1, reg_write_en=0.
//  3 instr_mem_ready held 0, MEM_TIMEOUT=16 -> HALT after 16 IWAIT cycles,
//    timeout_err=1, halted=1, cycle_count frozen; ready=1 on 16th cycle -> no error.
//  4 type=HALT at EXECUTE -> HALT next cycle; start pulses ignored; rst -> IDLE.
//  5 rst asserted during MWAIT -> next cycle all outputs at reset values.
//  6 JUMP with changing type during WB -> reg_write_en=0, returns to IWAIT.

Source files
------------

// File: rtl/stage_sequencer_pkg.sv
// Shared stage codes and instruction-type codes for the TinyCPU stage sequencer.
package stage_sequencer_pkg;

  localparam int unsigned STAGE_WIDTH = 3;
  localparam int unsigned INSTR_WIDTH = 5;

  typedef enum logic [STAGE_WIDTH-1:0] {
    StIdle      = 3'd0,
    StIwait     = 3'd1,
    StFetch     = 3'd2,
    StDecode    = 3'd3,
    StExecute   = 3'd4,
    StMwait     = 3'd5,
    StWriteback = 3'd6,
    StHalt      = 3'd7
  } stage_e;

  localparam logic [INSTR_WIDTH-1:0] INSTR_ADD   = 5'd0;
  localparam logic [INSTR_WIDTH-1:0] INSTR_SUB   = 5'd1;
  localparam logic [INSTR_WIDTH-1:0] INSTR_LOAD  = 5'd2;
  localparam logic [INSTR_WIDTH-1:0] INSTR_STORE = 5'd3;
  localparam logic [INSTR_WIDTH-1:0] INSTR_JUMP  = 5'd4;
  localparam logic [INSTR_WIDTH-1:0] INSTR_HALT  = 5'd31;

  // Stores and jumps retire without touching the register file.
  function automatic logic writes_reg(input logic [INSTR_WIDTH-1:0] instr_type);
    return !(instr_type == INSTR_STORE || instr_type == INSTR_JUMP);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts not-ready cycles of a memory wait; expired flags the last permitted wait cycle.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic ready,
  output logic expired
);

  localparam int unsigned CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (!ready) begin
      count <= count + 1'b1;
    end
  end

  assign expired = !clear && !ready && (count == LAST);

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle TinyCPU control FSM: stage code, memory request strobes, halt and timeout.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [INSTR_WIDTH-1:0] current_instruction_type,
  input  logic                   instr_mem_ready,
  input  logic                   data_mem_ready,
  output logic [STAGE_WIDTH-1:0] stage,
  output logic                   instr_mem_req,
  output logic                   data_mem_req,
  output logic                   data_mem_we,
  output logic                   reg_write_en,
  output logic                   halted,
  output logic                   timeout_err,
  output logic [CNT_WIDTH-1:0]   instr_count,
  output logic [CNT_WIDTH-1:0]   cycle_count
);

  stage_e                 state, state_next;
  logic [INSTR_WIDTH-1:0] instr_type, instr_type_next;
  logic                   in_wait, mem_ready, expired, timeout_next;

  assign in_wait   = (state == StIwait) || (state == StMwait);
  assign mem_ready = (state == StMwait) ? data_mem_ready : instr_mem_ready;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (!in_wait),
    .ready  (mem_ready),
    .expired(expired)
  );

  always_comb begin
    state_next      = state;
    timeout_next    = 1'b0;
    instr_type_next = (state == StExecute) ? current_instruction_type : instr_type;
    unique case (state)
      StIdle:    if (start) state_next = StIwait;
      StIwait: begin
        if (instr_mem_ready) begin
          state_next = StFetch;
        end else if (expired) begin
          state_next   = StHalt;
          timeout_next = 1'b1;
        end
      end
      StFetch:   state_next = StDecode;
      StDecode:  state_next = StExecute;
      StExecute: begin
        if (current_instruction_type == INSTR_HALT) begin
          state_next = StHalt;
        end else if (current_instruction_type == INSTR_LOAD ||
                     current_instruction_type == INSTR_STORE) begin
          state_next = StMwait;
        end else begin
          state_next = StWriteback;
        end
      end
      StMwait: begin
        if (data_mem_ready) begin
          state_next = StWriteback;
        end else if (expired) begin
          state_next   = StHalt;
          timeout_next = 1'b1;
        end
      end
      StWriteback: state_next = StIwait;
      StHalt:      state_next = StHalt;
      default:     state_next = StIdle;
    endcase
  end

  // Strobes are registered from the next state so they stay pure functions of the stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= StIdle;
      instr_type    <= '0;
      instr_mem_req <= 1'b0;
      data_mem_req  <= 1'b0;
      data_mem_we   <= 1'b0;
      reg_write_en  <= 1'b0;
      halted        <= 1'b0;
      timeout_err   <= 1'b0;
      instr_count   <= '0;
      cycle_count   <= '0;
    end else begin
      state         <= state_next;
      instr_type    <= instr_type_next;
      instr_mem_req <= (state_next == StIwait);
      data_mem_req  <= (state_next == StMwait);
      data_mem_we   <= (state_next == StMwait) && (instr_type_next == INSTR_STORE);
      reg_write_en  <= (state_next == StWriteback) && writes_reg(instr_type_next);
      halted        <= (state_next == StHalt);
      if (timeout_next) timeout_err <= 1'b1;
      if (state != StIdle && state != StHalt) cycle_count <= cycle_count + 1'b1;
      if (state == StWriteback) instr_count <= instr_count + 1'b1;
    end
  end

  assign stage = state;

endmodule

// File: tb/tb_stage_sequencer.sv
// Randomized bench: per-instruction plans expand into expected per-cycle traces and are replayed.
module tb_stage_sequencer;
  import stage_sequencer_pkg::*;

  localparam int unsigned MT = 16;

  logic        clk = 1'b0;
  logic        rst, start, instr_mem_ready, data_mem_ready;
  logic [4:0]  current_instruction_type;
  logic [2:0]  stage;
  logic        instr_mem_req, data_mem_req, data_mem_we, reg_write_en, halted, timeout_err;
  logic [31:0] instr_count, cycle_count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        rst, start, ir, dr;
    logic [4:0]  typ;
    logic [2:0]  st;
    logic        imreq, dmreq, dwe, rwe, hlt, terr;
    logic [31:0] icnt, ccnt;
  } cyc_t;

  cyc_t        plan[$];
  logic [31:0] m_icnt, m_ccnt;
  logic        m_terr;
  logic [4:0]  m_type;

  always #5 clk = ~clk;

  stage_sequencer #(
    .MEM_TIMEOUT(MT),
    .CNT_WIDTH  (32)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .start                   (start),
    .current_instruction_type(current_instruction_type),
    .instr_mem_ready         (instr_mem_ready),
    .data_mem_ready          (data_mem_ready),
    .stage                   (stage),
    .instr_mem_req           (instr_mem_req),
    .data_mem_req            (data_mem_req),
    .data_mem_we             (data_mem_we),
    .reg_write_en            (reg_write_en),
    .halted                  (halted),
    .timeout_err             (timeout_err),
    .instr_count             (instr_count),
    .cycle_count             (cycle_count)
  );

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [4:0] rt();
    return 5'($urandom);
  endfunction

  // Expected outputs for one cycle follow from the stage alone plus running totals.
  function automatic void push(logic [2:0] st, logic s, logic [4:0] typ, logic ir, logic dr,
                               logic r);
    cyc_t c;
    c.rst = r; c.start = s; c.typ = typ; c.ir = ir; c.dr = dr; c.st = st;
    c.imreq = (st == StIwait);
    c.dmreq = (st == StMwait);
    c.dwe   = (st == StMwait) && (m_type == INSTR_STORE);
    c.rwe   = (st == StWriteback) && (m_type != INSTR_STORE) && (m_type != INSTR_JUMP);
    c.hlt   = (st == StHalt);
    c.terr  = m_terr;
    c.icnt  = m_icnt;
    c.ccnt  = m_ccnt;
    plan.push_back(c);
    if (r) begin
      m_icnt = 0; m_ccnt = 0; m_terr = 0;
    end else begin
      if (st != StIdle && st != StHalt) m_ccnt++;
      if (st == StWriteback) m_icnt++;
    end
  endfunction

  function automatic void push_wait(logic [2:0] st, logic ready);
    push(st, rb(), rt(), (st == StIwait) ? ready : rb(), (st == StMwait) ? ready : rb(), 1'b0);
  endfunction

  // nwait not-ready cycles then ready; nwait >= MT means the wait times out.
  function automatic bit plan_wait(logic [2:0] st, int unsigned nwait);
    if (nwait >= MT) begin
      for (int i = 0; i < int'(MT); i++) push_wait(st, 1'b0);
      m_terr = 1'b1;
      return 1'b1;
    end
    for (int i = 0; i < int'(nwait); i++) push_wait(st, 1'b0);
    push_wait(st, 1'b1);
    return 1'b0;
  endfunction

  function automatic bit plan_instr(logic [4:0] typ, int unsigned iw, int unsigned dw);
    if (plan_wait(StIwait, iw)) return 1'b1;
    push(StFetch, rb(), rt(), rb(), rb(), 1'b0);
    push(StDecode, rb(), rt(), rb(), rb(), 1'b0);
    push(StExecute, rb(), typ, rb(), rb(), 1'b0);
    m_type = typ;
    if (typ == INSTR_HALT) return 1'b1;
    if (typ == INSTR_LOAD || typ == INSTR_STORE) begin
      if (plan_wait(StMwait, dw)) return 1'b1;
    end
    push(StWriteback, rb(), rt(), rb(), rb(), 1'b0);
    return 1'b0;
  endfunction

  function automatic void plan_start(int unsigned idle);
    for (int i = 0; i < int'(idle); i++) push(StIdle, 1'b0, rt(), rb(), rb(), 1'b0);
    push(StIdle, 1'b1, rt(), rb(), rb(), 1'b0);
  endfunction

  function automatic void plan_halt(int unsigned n);
    for (int i = 0; i < int'(n); i++) push(StHalt, rb(), rt(), rb(), rb(), 1'b0);
  endfunction

  task automatic begin_test();
    rst = 1'b1; start = 1'b1; instr_mem_ready = 1'b1; data_mem_ready = 1'b1;
    current_instruction_type = INSTR_ADD;
    repeat (2) @(negedge clk);
    rst = 1'b0; start = 1'b0;
    m_icnt = 0; m_ccnt = 0; m_terr = 1'b0; m_type = INSTR_ADD;
    plan.delete();
  endtask

  task automatic run_plan(string name);
    logic [72:0] got, exp;
    foreach (plan[i]) begin
      rst = plan[i].rst; start = plan[i].start; current_instruction_type = plan[i].typ;
      instr_mem_ready = plan[i].ir; data_mem_ready = plan[i].dr;
      got = {stage, instr_mem_req, data_mem_req, data_mem_we, reg_write_en, halted,
             timeout_err, instr_count, cycle_count};
      exp = {plan[i].st, plan[i].imreq, plan[i].dmreq, plan[i].dwe, plan[i].rwe, plan[i].hlt,
             plan[i].terr, plan[i].icnt, plan[i].ccnt};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL %s cycle %0d: stage/req/dreq/we/rwe/hlt/terr/icnt/ccnt got %h exp %h",
                 name, i, got, exp);
      end
      @(negedge clk);
    end
    rst = 1'b0;
    plan.delete();
  endtask

  task automatic test_reset();
    begin_test();
    plan_start(1);
    void'(plan_wait(StIwait, 0));
    push(StFetch, 1'b1, INSTR_HALT, 1'b1, 1'b1, 1'b1);
    plan_start(0);
    void'(plan_instr(INSTR_ADD, 0, 0));
    push(StIwait, 1'b0, rt(), 1'b0, rb(), 1'b0);
    run_plan("reset");
  endtask

  task automatic test_add();
    begin_test();
    plan_start(0);
    void'(plan_instr(INSTR_ADD, 0, 0));
    void'(plan_instr(INSTR_SUB, 2, 0));
    push(StIwait, 1'b0, rt(), 1'b0, rb(), 1'b0);
    run_plan("add");
  endtask

  task automatic test_load_store();
    begin_test();
    plan_start(0);
    void'(plan_instr(INSTR_LOAD, 0, 2));
    void'(plan_instr(INSTR_STORE, 0, 2));
    void'(plan_instr(INSTR_LOAD, 1, 0));
    void'(plan_instr(INSTR_STORE, 0, MT - 1));
    push(StIwait, 1'b0, rt(), 1'b0, rb(), 1'b0);
    run_plan("load_store");
  endtask

  task automatic test_timeout();
    begin_test();
    plan_start(0);
    void'(plan_instr(INSTR_ADD, MT - 1, 0));
    void'(plan_instr(INSTR_ADD, MT, 0));
    plan_halt(4);
    run_plan("iwait_timeout");
    begin_test();
    plan_start(0);
    void'(plan_instr(INSTR_LOAD, 0, MT));
    plan_halt(3);
    run_plan("mwait_timeout");
  endtask

  task automatic test_halt();
    begin_test();
    plan_start(2);
    void'(plan_instr(INSTR_ADD, 0, 0));
    void'(plan_instr(INSTR_HALT, 0, 0));
    for (int i = 0; i < 4; i++) push(StHalt, 1'b1, rt(), 1'b1, 1'b1, 1'b0);
    push(StHalt, 1'b0, rt(), rb(), rb(), 1'b1);
    push(StIdle, 1'b0, rt(), rb(), rb(), 1'b0);
    push(StIdle, 1'b0, rt(), rb(), rb(), 1'b0);
    run_plan("halt");
  endtask

  task automatic test_reset_mid_wait();
    begin_test();
    plan_start(0);
    void'(plan_instr(INSTR_ADD, 0, 0));
    void'(plan_wait(StIwait, 0));
    push(StFetch, rb(), rt(), rb(), rb(), 1'b0);
    push(StDecode, rb(), rt(), rb(), rb(), 1'b0);
    push(StExecute, rb(), INSTR_STORE, rb(), rb(), 1'b0);
    m_type = INSTR_STORE;
    push(StMwait, rb(), rt(), rb(), 1'b0, 1'b0);
    push(StMwait, rb(), rt(), rb(), 1'b0, 1'b0);
    push(StMwait, 1'b1, rt(), 1'b1, 1'b1, 1'b1);
    push(StIdle, 1'b0, rt(), rb(), rb(), 1'b0);
    plan_start(0);
    void'(plan_instr(INSTR_LOAD, 0, 0));
    run_plan("reset_mid_wait");
  endtask

  task automatic test_jump();
    begin_test();
    plan_start(0);
    void'(plan_instr(INSTR_JUMP, 0, 0));
    void'(plan_instr(INSTR_JUMP, 1, 0));
    void'(plan_instr(INSTR_ADD, 0, 0));
    push(StIwait, 1'b0, rt(), 1'b0, rb(), 1'b0);
    run_plan("jump");
  endtask

  task automatic test_random();
    logic [4:0] typ;
    int unsigned iw, dw, sel;
    bit stop;
    for (int run = 0; run < 4; run++) begin
      begin_test();
      plan_start($urandom_range(0, 2));
      stop = 1'b0;
      for (int k = 0; k < 25 && !stop; k++) begin
        sel = $urandom_range(0, 99);
        if (sel < 2) typ = INSTR_HALT;
        else if (sel < 25) typ = INSTR_LOAD;
        else if (sel < 45) typ = INSTR_STORE;
        else if (sel < 60) typ = INSTR_JUMP;
        else begin
          typ = rt();
          if (typ == INSTR_HALT) typ = INSTR_SUB;
        end
        iw = ($urandom_range(0, 99) < 3) ? MT : $urandom_range(0, 3);
        dw = ($urandom_range(0, 99) < 3) ? MT : $urandom_range(0, 4);
        if ($urandom_range(0, 9) == 0) iw = MT - 1;
        stop = plan_instr(typ, iw, dw);
      end
      if (stop) plan_halt(3);
      run_plan("random");
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; instr_mem_ready = 1'b0; data_mem_ready = 1'b0;
    current_instruction_type = '0;
    @(negedge clk);
    test_reset();
    test_add();
    test_load_store();
    test_timeout();
    test_halt();
    test_reset_mid_wait();
    test_jump();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
